// File: rtl/fu_pkg.sv
// Types and widths shared between the reservation station and the FU side of fu_if.
package fu_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned PRN_W      = 7;
  localparam int unsigned ID_W       = 6;
  localparam int unsigned RS_NUM_OPS = 3;
  localparam int unsigned RS_NUM_OUT = 3;

  typedef struct packed {
    logic [PRN_W-1:0]  prn;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } rs_op_t;

  // Station entry layout for the default operand/destination counts.
  typedef struct packed {
    logic                             valid;
    logic [31:0]                      inst;
    logic [ID_W-1:0]                  id;
    logic [RS_NUM_OUT-1:0][PRN_W-1:0] out_prn;
    rs_op_t [RS_NUM_OPS-1:0]          ops;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Priority encoder: returns the lowest set index of the eligible vector.
module rs_oldest_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    eligible,
  output logic [IdxW-1:0] idx,
  output logic            found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        idx   = IdxW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fu_issue_station.sv
// Collapsing-queue reservation station feeding one functional unit; issues the
// oldest entry whose operands are all ready.
module fu_issue_station #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned NUM_OPS = 3,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned PRN_W   = fu_pkg::PRN_W,
  parameter int unsigned ID_W    = fu_pkg::ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [31:0]               disp_inst,
  input  logic [ID_W-1:0]           disp_inst_id,
  input  logic [PRN_W-1:0]          disp_op_prn  [NUM_OPS],
  input  logic [NUM_OPS-1:0]        disp_op_rdy,
  input  logic [fu_pkg::DATA_W-1:0] disp_op_data [NUM_OPS],
  input  logic [PRN_W-1:0]          disp_out_prn [NUM_OUT],
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [PRN_W-1:0]          cdb_prn      [NUM_CDB],
  input  logic [fu_pkg::DATA_W-1:0] cdb_data     [NUM_CDB],
  input  logic                      fu_ready,
  output logic [31:0]               inst,
  output logic                      inst_valid,
  output logic [ID_W-1:0]           inst_id,
  output logic [fu_pkg::DATA_W-1:0] op           [NUM_OPS],
  output logic [PRN_W-1:0]          out_prn      [NUM_OUT]
);

  localparam int unsigned DataW = fu_pkg::DATA_W;
  localparam int unsigned CntW  = $clog2(ENTRIES + 1);
  localparam int unsigned IdxW  = $clog2(ENTRIES);

  typedef struct packed {
    logic                          valid;
    logic [31:0]                   inst;
    logic [ID_W-1:0]               id;
    logic [NUM_OUT-1:0][PRN_W-1:0] out_prn;
    logic [NUM_OPS-1:0][PRN_W-1:0] prn;
    logic [NUM_OPS-1:0]            rdy;
    logic [NUM_OPS-1:0][DataW-1:0] data;
  } entry_t;

  entry_t           entries_q [ENTRIES];
  entry_t           entries_d [ENTRIES];
  entry_t           woke      [ENTRIES+1];
  entry_t           disp_ent;
  logic [CntW-1:0]  count_q, count_d, wr_slot;
  logic [ENTRIES-1:0] eligible;
  logic [IdxW-1:0]  sel_idx;
  logic             sel_found, issue, disp_fire;

  // CDB snoop: lowest-numbered matching port wins, hence the descending scan.
  function automatic entry_t snoop(entry_t e, logic [NUM_CDB-1:0] v,
                                   logic [PRN_W-1:0] p [NUM_CDB],
                                   logic [DataW-1:0] d [NUM_CDB]);
    for (int j = 0; j < NUM_OPS; j++) begin
      if (e.valid && !e.rdy[j]) begin
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
          if (v[k] && p[k] == e.prn[j]) begin
            e.rdy[j]  = 1'b1;
            e.data[j] = d[k];
          end
        end
      end
    end
    return e;
  endfunction

  rs_oldest_select #(
    .N    (ENTRIES),
    .IdxW (IdxW)
  ) u_select (
    .eligible (eligible),
    .idx      (sel_idx),
    .found    (sel_found)
  );

  always_comb begin
    disp_ready = !rst && (count_q < CntW'(ENTRIES));
    disp_fire  = disp_valid && disp_ready;
    for (int i = 0; i < ENTRIES; i++) begin
      eligible[i] = entries_q[i].valid && (&entries_q[i].rdy);
    end
    issue = fu_ready && sel_found;

    disp_ent       = '0;
    disp_ent.valid = 1'b1;
    disp_ent.inst  = disp_inst;
    disp_ent.id    = disp_inst_id;
    for (int j = 0; j < NUM_OUT; j++) disp_ent.out_prn[j] = disp_out_prn[j];
    for (int j = 0; j < NUM_OPS; j++) begin
      disp_ent.prn[j]  = disp_op_prn[j];
      disp_ent.rdy[j]  = disp_op_rdy[j];
      disp_ent.data[j] = disp_op_rdy[j] ? disp_op_data[j] : '0;
    end
    disp_ent = snoop(disp_ent, cdb_valid, cdb_prn, cdb_data);

    for (int i = 0; i < ENTRIES; i++) woke[i] = snoop(entries_q[i], cdb_valid, cdb_prn, cdb_data);
    woke[ENTRIES] = '0;

    // The slot freed by an issue is filled by the shift, so dispatch lands one lower.
    wr_slot = issue ? count_q - CntW'(1) : count_q;
    for (int i = 0; i < ENTRIES; i++) begin
      entries_d[i] = (issue && IdxW'(i) >= sel_idx) ? woke[i+1] : woke[i];
      if (disp_fire && CntW'(i) == wr_slot) entries_d[i] = disp_ent;
    end
    count_d = count_q + CntW'(disp_fire) - CntW'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      count_q    <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_id    <= '0;
      for (int j = 0; j < NUM_OPS; j++) op[j] <= '0;
      for (int j = 0; j < NUM_OUT; j++) out_prn[j] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      count_q    <= '0;
      inst_valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= entries_d[i];
      count_q    <= count_d;
      inst_valid <= issue;
      if (issue) begin
        inst    <= entries_q[sel_idx].inst;
        inst_id <= entries_q[sel_idx].id;
        for (int j = 0; j < NUM_OPS; j++) op[j] <= entries_q[sel_idx].data[j];
        for (int j = 0; j < NUM_OUT; j++) out_prn[j] <= entries_q[sel_idx].out_prn[j];
      end
    end
  end

endmodule

// File: tb/tb_fu_issue_station.sv
// Bench for fu_issue_station: directed scenarios then random traffic, checked
// against a queue-based model of the station.
module tb_fu_issue_station;
  import fu_pkg::*;

  localparam int NE = 4;
  localparam int NO = 3;
  localparam int NU = 3;
  localparam int NC = 2;
  localparam int PW = 7;
  localparam int IW = 6;
  localparam int DW = 64;

  logic          clk, rst, flush, disp_valid, disp_ready, fu_ready;
  logic [31:0]   disp_inst;
  logic [IW-1:0] disp_inst_id;
  logic [PW-1:0] disp_op_prn [NO];
  logic [NO-1:0] disp_op_rdy;
  logic [DW-1:0] disp_op_data [NO];
  logic [PW-1:0] disp_out_prn [NU];
  logic [NC-1:0] cdb_valid;
  logic [PW-1:0] cdb_prn [NC];
  logic [DW-1:0] cdb_data [NC];
  logic [31:0]   inst;
  logic          inst_valid;
  logic [IW-1:0] inst_id;
  logic [DW-1:0] op [NO];
  logic [PW-1:0] out_prn [NU];

  fu_issue_station #(
    .ENTRIES (NE), .NUM_OPS (NO), .NUM_OUT (NU), .NUM_CDB (NC), .PRN_W (PW), .ID_W (IW)
  ) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .disp_valid (disp_valid), .disp_ready (disp_ready), .disp_inst (disp_inst),
    .disp_inst_id (disp_inst_id), .disp_op_prn (disp_op_prn), .disp_op_rdy (disp_op_rdy),
    .disp_op_data (disp_op_data), .disp_out_prn (disp_out_prn),
    .cdb_valid (cdb_valid), .cdb_prn (cdb_prn), .cdb_data (cdb_data),
    .fu_ready (fu_ready), .inst (inst), .inst_valid (inst_valid), .inst_id (inst_id),
    .op (op), .out_prn (out_prn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]           inst;
    logic [IW-1:0]         id;
    logic [NU-1:0][PW-1:0] outp;
    logic [NO-1:0][PW-1:0] prn;
    logic [NO-1:0]         rdy;
    logic [NO-1:0][DW-1:0] data;
  } m_ent_t;

  m_ent_t                mq [$];
  logic                  e_valid;
  logic [31:0]           e_inst;
  logic [IW-1:0]         e_id;
  logic [NO-1:0][DW-1:0] e_op;
  logic [NU-1:0][PW-1:0] e_out;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Non-ready operands take the value of the lowest-numbered matching broadcast.
  function automatic m_ent_t m_wake(m_ent_t e);
    for (int j = 0; j < NO; j++) begin
      bit hit = 0;
      if (!e.rdy[j]) begin
        for (int k = 0; k < NC; k++) begin
          if (!hit && cdb_valid[k] && cdb_prn[k] == e.prn[j]) begin
            hit = 1;
            e.rdy[j]  = 1'b1;
            e.data[j] = cdb_data[k];
          end
        end
      end
    end
    return e;
  endfunction

  task automatic step();
    int sz;
    int pick;
    m_ent_t ne;
    #1;
    sz = mq.size();
    check("disp_ready", {63'd0, disp_ready}, {63'd0, (!rst && sz < NE)});
    if (rst) begin
      mq.delete();
      e_valid = 0; e_inst = '0; e_id = '0; e_op = '0; e_out = '0;
    end else if (flush) begin
      mq.delete();
      e_valid = 0;
    end else begin
      e_valid = 0;
      pick = -1;
      if (fu_ready)
        for (int i = 0; i < mq.size(); i++) if (pick < 0 && (&mq[i].rdy)) pick = i;
      if (pick >= 0) begin
        e_valid = 1;
        e_inst  = mq[pick].inst;
        e_id    = mq[pick].id;
        e_op    = mq[pick].data;
        e_out   = mq[pick].outp;
        mq.delete(pick);
      end
      for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
      if (disp_valid && sz < NE) begin
        ne.inst = disp_inst;
        ne.id   = disp_inst_id;
        for (int j = 0; j < NU; j++) ne.outp[j] = disp_out_prn[j];
        for (int j = 0; j < NO; j++) begin
          ne.prn[j]  = disp_op_prn[j];
          ne.rdy[j]  = disp_op_rdy[j];
          ne.data[j] = disp_op_rdy[j] ? disp_op_data[j] : '0;
        end
        mq.push_back(m_wake(ne));
      end
    end
    @(posedge clk);
    #1;
    check("inst_valid", {63'd0, inst_valid}, {63'd0, e_valid});
    check("inst", {32'd0, inst}, {32'd0, e_inst});
    check("inst_id", {58'd0, inst_id}, {58'd0, e_id});
    for (int j = 0; j < NO; j++) check($sformatf("op[%0d]", j), op[j], e_op[j]);
    for (int j = 0; j < NU; j++)
      check($sformatf("out_prn[%0d]", j), {57'd0, out_prn[j]}, {57'd0, e_out[j]});
  endtask

  task automatic idle();
    disp_valid = 0;
    cdb_valid  = '0;
    flush      = 0;
  endtask

  task automatic drive_disp(input int id, input logic [31:0] w, input logic [NO-1:0] rdy,
                            input int p0, input int p1, input int p2, input logic [63:0] seed);
    disp_valid      = 1;
    disp_inst       = w;
    disp_inst_id    = IW'(id);
    disp_op_rdy     = rdy;
    disp_op_prn[0]  = PW'(p0);
    disp_op_prn[1]  = PW'(p1);
    disp_op_prn[2]  = PW'(p2);
    for (int j = 0; j < NO; j++) disp_op_data[j] = seed + 64'(j);
    for (int j = 0; j < NU; j++) disp_out_prn[j] = PW'(id + 40 + j);
  endtask

  task automatic bcast(input int k, input int prn, input logic [63:0] d);
    cdb_valid[k] = 1'b1;
    cdb_prn[k]   = PW'(prn);
    cdb_data[k]  = d;
  endtask

  initial begin
    rst = 1; fu_ready = 0; idle();
    disp_inst = '0; disp_inst_id = '0; disp_op_rdy = '0;
    for (int j = 0; j < NO; j++) begin disp_op_prn[j] = '0; disp_op_data[j] = '0; end
    for (int j = 0; j < NU; j++) disp_out_prn[j] = '0;
    for (int k = 0; k < NC; k++) begin cdb_prn[k] = '0; cdb_data[k] = '0; end
    step(); step();
    rst = 0; step();

    // All-ready CSEL issues two edges after dispatch, for one cycle.
    fu_ready = 1;
    drive_disp(5, 32'h9A80_1000, 3'b111, 1, 2, 3, 64'h100); step();
    idle(); step();
    check("csel_id", {58'd0, inst_id}, 64'd5);
    check("csel_op2", op[2], 64'h102);
    step();
    check("csel_pulse", {63'd0, inst_valid}, 64'd0);

    // op1 waits on prn 9; broadcast three cycles later.
    drive_disp(1, 32'h8A00_0001, 3'b101, 8, 9, 10, 64'h200); step();
    idle(); step(); step(); step();
    bcast(0, 9, 64'hDEAD); step();
    idle(); step();
    check("wake_valid", {63'd0, inst_valid}, 64'd1);
    check("wake_op1", op[1], 64'hDEAD);
    step();

    // Fill with stalled entries, refuse a fifth, wake entry 2 only.
    for (int i = 0; i < 4; i++) begin
      drive_disp(10 + i, 32'h1000 + i, 3'b110, 20 + i, 0, 0, 64'h300 + 64'(16 * i)); step();
    end
    drive_disp(14, 32'h2000, 3'b111, 0, 0, 0, 64'h400); step();
    idle();
    check("full_ready", {63'd0, disp_ready}, 64'd0);
    bcast(0, 22, 64'h22); step();
    idle(); step();
    check("mid_issue_id", {58'd0, inst_id}, 64'd12);
    step();
    bcast(0, 20, 64'h20); bcast(1, 21, 64'h21); step();
    idle(); step(); step();
    bcast(1, 23, 64'h23); step();
    idle(); step(); step();

    // Full while issuing: same-edge dispatch is refused, issue proceeds.
    fu_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_disp(20 + i, 32'h3000 + i, 3'b111, 0, 0, 0, 64'h500 + 64'(16 * i)); step();
    end
    drive_disp(24, 32'h3100, 3'b111, 0, 0, 0, 64'h600); fu_ready = 1; step();
    idle(); step(); step(); step(); step();

    // Dispatch-time bypass, and lowest CDB port wins on a double match.
    drive_disp(30, 32'h4000, 3'b110, 33, 34, 35, 64'h700);
    bcast(0, 50, 64'hBAD); bcast(1, 33, 64'hB1); step();
    idle(); step();
    check("bypass_op0", op[0], 64'hB1);
    drive_disp(31, 32'h4001, 3'b110, 33, 34, 35, 64'h800);
    bcast(0, 33, 64'hA0); bcast(1, 33, 64'hA1); step();
    idle(); step();
    check("lowk_op0", op[0], 64'hA0);

    // fu_ready low holds two ready entries; oldest goes first afterwards.
    fu_ready = 0;
    drive_disp(40, 32'h5000, 3'b111, 0, 0, 0, 64'h900); step();
    drive_disp(41, 32'h5001, 3'b111, 0, 0, 0, 64'hA00); step();
    idle(); step(); step(); step();
    fu_ready = 1; step();
    check("order_first", {58'd0, inst_id}, 64'd40);
    step();
    check("order_second", {58'd0, inst_id}, 64'd41);
    step();

    // Flush with three stalled entries plus a same-edge dispatch.
    for (int i = 0; i < 3; i++) begin
      drive_disp(50 + i, 32'h6000 + i, 3'b110, 60 + i, 0, 0, 64'hB00); step();
    end
    drive_disp(45, 32'h6100, 3'b111, 0, 0, 0, 64'hC00); flush = 1; step();
    idle(); bcast(0, 60, 64'h1); bcast(1, 61, 64'h2); step();
    idle(); bcast(0, 62, 64'h3); step();
    idle(); step();
    check("flush_quiet", {63'd0, inst_valid}, 64'd0);
    step();

    // Reset mid-operation drops ready entries.
    fu_ready = 0;
    drive_disp(7, 32'h7000, 3'b111, 0, 0, 0, 64'hD00); step();
    drive_disp(8, 32'h7001, 3'b111, 0, 0, 0, 64'hE00); step();
    idle(); fu_ready = 1; rst = 1; step();
    rst = 0; step(); step();

    // Random traffic over a small PRN pool so broadcasts hit often.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst          = ($urandom % 120) == 0;
      flush        = ($urandom % 40) == 0;
      fu_ready     = ($urandom % 4) != 0;
      disp_valid   = $urandom % 2;
      disp_inst    = $urandom;
      disp_inst_id = IW'($urandom);
      disp_op_rdy  = NO'($urandom);
      for (int j = 0; j < NO; j++) begin
        disp_op_prn[j]  = PW'($urandom % 12);
        disp_op_data[j] = {$urandom, $urandom};
      end
      for (int j = 0; j < NU; j++) disp_out_prn[j] = PW'($urandom);
      cdb_valid = NC'($urandom);
      for (int k = 0; k < NC; k++) begin
        cdb_prn[k]  = PW'($urandom % 12);
        cdb_data[k] = {$urandom, $urandom};
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_issue_station.md
# fu_issue_station

Reservation station that drives the issue side of `fu_if`: the initiator feeding one functional unit (e.g. the logical FU). Accepts renamed instructions from dispatch, holds them until all source operands are available (captured at dispatch or snooped from the common data bus), then issues the oldest ready entry to the FU with a one-cycle `inst_valid` pulse while `fu_ready` is high. Sits between rename/dispatch and one FU instance.

## Interface
Parameters:
- `ENTRIES`, 4: station depth, at least 2.
- `NUM_OPS`, 3: source operands per instruction; operand 2 carries flags (NZCV in `[3:0]`) for conditional ops.
- `NUM_OUT`, 3: destination PRNs per instruction.
- `NUM_CDB`, 2: CDB broadcast ports snooped.
- `PRN_W`, 7: physical register number width.
- `ID_W`, 6: instruction id width.

Ports (scalar unless noted; per-operand/port arrays indexed `[NUM_OPS]`/`[NUM_OUT]`/`[NUM_CDB]`):
- `clk`  in  1  clock (the `fu_if` clock).
- `rst`  in  1  synchronous, active-high reset (the `fu_if` reset).
- `flush`  in  1  synchronous squash of all entries and pending issue.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  space available.
- `disp_inst`  in  32  instruction word.
- `disp_inst_id`  in  ID_W  instruction id.
- `disp_op_prn`  in  PRN_W x NUM_OPS  source PRNs.
- `disp_op_rdy`  in  NUM_OPS  operand value already valid.
- `disp_op_data`  in  64 x NUM_OPS  operand values, used where `disp_op_rdy` is set.
- `disp_out_prn`  in  PRN_W x NUM_OUT  destination PRNs.
- `cdb_valid`  in  NUM_CDB  broadcast valid.
- `cdb_prn`  in  PRN_W x NUM_CDB  broadcast PRN.
- `cdb_data`  in  64 x NUM_CDB  broadcast value.
- `fu_ready`  in  1  FU can accept an instruction this cycle.
- `inst`  out  32  issued instruction word.
- `inst_valid`  out  1  issue pulse.
- `inst_id`  out  ID_W  issued id.
- `op`  out  64 x NUM_OPS  issued operand values.
- `out_prn`  out  PRN_W x NUM_OUT  issued destination PRNs.

## Operation
- Storage: collapsing queue; entry 0 is oldest. Each entry holds valid, inst, id, out_prn, and per operand {prn, rdy, data}. `count` is the number of valid entries.
- Dispatch: accept when `disp_valid && disp_ready`. Write into slot `count` minus one if an issue occurs the same edge, else slot `count`.
- `disp_ready = !rst && count < ENTRIES` (registered count; no credit for a same-cycle issue).
- Wakeup: on each edge, every non-ready operand whose prn matches a valid `cdb_prn[k]` sets rdy and captures `cdb_data[k]`. Dispatching operands with `disp_op_rdy=0` also match the same-cycle CDB (bypass), so no broadcast is lost.
- Multiple CDB matches on one operand: lowest `k` wins.
- Select: entry is eligible when valid and all rdy bits are set (registered bits). When `fu_ready`, the lowest-index eligible entry is issued: loaded into the output registers and removed, and higher entries shift down one slot with their wakeups applied.
- Outputs are registered. `inst_valid` is high for exactly one cycle per issue. `inst`/`inst_id`/`op`/`out_prn` hold their last issued value otherwise.
- `flush` (priority below `rst`, above everything else): clears all valid bits and forces `inst_valid=0` next cycle; the dispatch on that edge is dropped.

## Timing
- Reset values: `inst_valid=0`, `inst=0`, `inst_id=0`, `op=0`, `out_prn=0`, all entries invalid, `count=0`; `disp_ready=0` while `rst` is high, 1 the cycle after.
- Latency, all-ready dispatch accepted at edge E0:
  - eligible in the cycle after E0;
  - output loaded at E1, so `inst_valid` is high between E1 and E2;
  - the FU samples at E2.
- Wakeup-to-issue: CDB at edge E0 sets rdy; the entry is selectable in the following cycle, giving `inst_valid` after E1.
- Back-to-back issue every cycle while `fu_ready` stays high and eligible entries exist.
- `fu_ready` low: no select, entries retained.
- Full, with dispatch and issue on the same edge: the dispatch is refused (`disp_ready=0`); the issue proceeds.
- Reset mid-operation: all state discarded; no `inst_valid` in the cycle after reset.

## Structure
- Shared package `fu_pkg`:
  - `rs_entry_t` packed struct;
  - `PRN_W`, `ID_W`, and data width 64 constants, shared with the FU side of `fu_if`.
- Sub-module `rs_oldest_select`: combinational priority encoder over the eligible vector, returning index plus found. Wakeup CAM stays inline.

## Test plan
- Reset then dispatch id=5 `CSEL` with all operands ready and `fu_ready=1` → `inst_valid` exactly one cycle, 2 edges after dispatch, with `inst_id=5` and `op`/`out_prn` matching.
- Dispatch id=1 with op1 prn=9 not ready; pulse `cdb_valid[0]`, prn=9, data=0xDEAD three cycles later → issued one cycle after the CDB edge with `op[1]=0xDEAD`.
- Fill 4 entries with stalled ops → `disp_ready=0`; wake entry 2 only → entry 2 issues, `disp_ready` returns, entries 0, 1, 3 retain order.
- Dispatch with `disp_op_rdy[0]=0` in the same cycle `cdb_prn` matches → captured; issues without further broadcast.
- Two ready entries with `fu_ready=0` for 3 cycles, then 1 → no issue while low, then older id first, younger the next cycle.
- `flush` with 3 valid entries → `count=0`, no `inst_valid`; same-edge dispatch not retained.
